fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, 64'h0, first fetch address after reset SHALL be this value.
REQ-002 Parameter TRAP_VEC, 64'h100, redirect address SHALL be this value on misaligned-target trap (FETCH_TRAP_EN only).
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  SHALL be asynchronous and active-high.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  64  fetch address.
REQ-007 imem_gnt  input  1  memory accepts the request this cycle.
REQ-008 imem_rvalid  input  1  read data valid.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 inst_valid  output  1  instruction available to decode.
REQ-011 inst  output  32  instruction word.
REQ-012 inst_pc  output  64  address of inst.
REQ-013 inst_ready  input  1  decode accepts inst this cycle.
REQ-014 redirect  input  1  branch/jump taken; restart fetch.
REQ-015 redirect_pc  input  64  new fetch address, sampled when redirect=1.
REQ-016 trap  output  1  one-cycle pulse on misaligned redirect.

Function
REQ-017 States SHALL be IDLE, REQ, WAIT, OUT; register pc holds the current fetch address.
REQ-018 IDLE: outputs inactive; SHALL go to REQ on the next cycle.
REQ-019 REQ: imem_req=1, imem_addr=pc; on imem_gnt SHALL go to WAIT; imem_addr SHALL remain stable while imem_req=1 and imem_gnt=0.
REQ-020 WAIT: on imem_rvalid SHALL capture imem_rdata into inst and pc into inst_pc, then go to OUT.
REQ-021 OUT: inst_valid=1, inst and inst_pc stable until inst_ready; on inst_ready, pc SHALL become pc+4 and the state SHALL become REQ.
REQ-022 Fetch-to-inst_valid latency SHALL be 2 cycles minimum (gnt in REQ, rvalid in the next cycle, inst_valid in the following cycle).
REQ-023 pc+4 SHALL wrap modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC -> 64'h0).
REQ-024 redirect in IDLE or REQ: pc SHALL be set to redirect_pc and the state SHALL become REQ; a same-cycle imem_gnt SHALL be treated as accepted and its response discarded.
REQ-025 redirect in WAIT: pc SHALL be set to redirect_pc; the outstanding response SHALL be discarded when it arrives (this cycle or later), then the state SHALL become REQ.
REQ-026 redirect in OUT without inst_ready: inst_valid SHALL drop next cycle; the instruction is discarded; pc SHALL be set to redirect_pc; the state SHALL become REQ.
REQ-027 redirect and inst_ready in the same OUT cycle: the handshake SHALL complete, and pc SHALL be set to redirect_pc (not pc+4).
REQ-028 At most one fetch SHALL be outstanding; imem_rvalid outside WAIT or the discard window SHALL be ignored.
REQ-029 trap SHALL be 0 whenever FETCH_TRAP_EN is undefined.

Reset
REQ-030 While reset=1: state SHALL be IDLE, pc=RESET_PC, imem_req=0, inst_valid=0, trap=0, inst=0, inst_pc=0, and the discard flag SHALL be cleared.
REQ-031 Reset asserted mid-fetch SHALL abandon the outstanding request; a late imem_rvalid after reset release, before the first grant, SHALL be ignored.

Configuration
REQ-032 Macro FETCH_TRAP_EN defined: a redirect with redirect_pc[1:0]!=0 SHALL set pc=TRAP_VEC instead of redirect_pc and pulse trap for one cycle.
REQ-033 Macro FETCH_TRAP_EN undefined: redirect_pc SHALL be used unchanged, including low bits; trap SHALL be tied to 0.

Verification
REQ-034 Reset release, imem_gnt=1 always, imem_rvalid one cycle after gnt, inst_ready=1 -> imem_addr sequence 0,4,8; inst_pc matches; first inst_valid 3 cycles after reset release.
REQ-035 imem_gnt held 0 for 5 cycles in REQ -> imem_addr stays 0x0 with imem_req=1; WAIT is entered only after gnt.
REQ-036 redirect=1, redirect_pc=0x200 while in WAIT for addr 0x8 -> response for 0x8 is never presented; next imem_addr=0x200.
REQ-037 inst_ready=0 for 4 cycles in OUT -> inst and inst_pc stable; inst_ready and redirect to 0x40 in the same cycle -> instruction consumed once; next fetch at 0x40.
REQ-038 pc=64'hFFFF_FFFF_FFFF_FFFC consumed -> next imem_addr=0x0.
REQ-039 With FETCH_TRAP_EN: redirect_pc=0x202 -> trap pulses one cycle; next imem_addr=TRAP_VEC (0x100). Without FETCH_TRAP_EN -> next imem_addr=0x202; trap stays 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch sequencer: IDLE -> REQ -> WAIT -> OUT, with redirect handling.
// Optional macro FETCH_TRAP_EN: a misaligned redirect target vectors to TRAP_VEC and pulses trap.
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [63:0] TRAP_VEC = 64'h100
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        trap
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]  state_reg, state_next;
  logic [63:0] pc_reg, pc_next;
  logic [31:0] inst_reg, inst_next;
  logic [63:0] inst_pc_reg, inst_pc_next;
  logic        discard_reg, discard_next;
  logic        trap_reg, trap_next;

  logic        grant;
  logic        misaligned;
  logic [63:0] redirect_target;

`ifdef FETCH_TRAP_EN
  assign misaligned      = redirect && (redirect_pc[1:0] != 2'b00);
  assign redirect_target = misaligned ? TRAP_VEC : redirect_pc;
`else
  logic unused_trap_vec;
  assign unused_trap_vec = ^TRAP_VEC;
  assign misaligned      = 1'b0;
  assign redirect_target = redirect_pc;
`endif

  // A pending discard blocks new requests so that only one fetch is ever in flight.
  assign imem_req   = (state_reg == S_REQ) && !discard_reg;
  assign imem_addr  = pc_reg;
  assign grant      = imem_req && imem_gnt;
  assign inst_valid = (state_reg == S_OUT);
  assign inst       = inst_reg;
  assign inst_pc    = inst_pc_reg;
  assign trap       = trap_reg;

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    inst_next    = inst_reg;
    inst_pc_next = inst_pc_reg;
    discard_next = discard_reg;
    trap_next    = 1'b0;

    if (discard_reg && imem_rvalid)
      discard_next = 1'b0;

    case (state_reg)
      S_IDLE: state_next = S_REQ;
      S_REQ: begin
        if (grant)
          state_next = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid && !discard_reg) begin
          inst_next    = imem_rdata;
          inst_pc_next = pc_reg;
          state_next   = S_OUT;
        end
      end
      S_OUT: begin
        if (inst_ready) begin
          pc_next    = pc_reg + 64'd4;
          state_next = S_REQ;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Redirect overrides sequential flow; any in-flight response becomes a discard.
    if (redirect) begin
      pc_next    = redirect_target;
      state_next = S_REQ;
      trap_next  = misaligned;
      case (state_reg)
        S_REQ: begin
          if (grant)
            discard_next = 1'b1;
        end
        S_WAIT: begin
          inst_next    = inst_reg;
          inst_pc_next = inst_pc_reg;
          if (!imem_rvalid)
            discard_next = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      pc_reg      <= RESET_PC;
      inst_reg    <= '0;
      inst_pc_reg <= '0;
      discard_reg <= 1'b0;
      trap_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      inst_reg    <= inst_next;
      inst_pc_reg <= inst_pc_next;
      discard_reg <= discard_next;
      trap_reg    <= trap_next;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected fetch addresses and delivered instructions are
// queued by the scenarios and popped by the memory model / decode monitor.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        trap;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [63:0] exp_addr_q[$];
  logic [63:0] exp_inst_q[$];

  bit          gnt_en   = 1'b0;
  int          rv_delay = 0;
  bit          pend     = 1'b0;
  logic [63:0] pend_addr = 64'h0;
  int          pend_wait = 0;
  logic [63:0] mon_pc;

  fetch_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .trap        (trap)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Memory model: grant decision and response at negedge+1, rvalid rv_delay cycles after the grant cycle.
  always @(negedge clk) begin
    #1;
    imem_rvalid = 1'b0;
    if (pend) begin
      if (pend_wait == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pend        = 1'b0;
      end else begin
        pend_wait--;
      end
    end
    imem_gnt = gnt_en;
    if (imem_req && imem_gnt && !reset) begin
      $display("grant   addr=%h", imem_addr);
      check("fetch_expected", 64'(exp_addr_q.size() != 0), 64'd1);
      if (exp_addr_q.size() != 0)
        check("fetch_addr", imem_addr, exp_addr_q.pop_front());
      pend      = 1'b1;
      pend_addr = imem_addr;
      pend_wait = rv_delay;
    end
  end

  // Decode monitor: a handshake happens at the next posedge when both are high now.
  always @(negedge clk) begin
    #2;
    if (!reset && inst_valid && inst_ready) begin
      $display("consume pc=%h inst=%h", inst_pc, inst);
      check("inst_expected", 64'(exp_inst_q.size() != 0), 64'd1);
      if (exp_inst_q.size() != 0) begin
        mon_pc = exp_inst_q.pop_front();
        check("inst_pc", inst_pc, mon_pc);
        check("inst_word", 64'(inst), 64'(mem_word(mon_pc)));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; gnt_en = 1'b0; redirect = 1'b0; inst_ready = 1'b0; rv_delay = 0;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic push_fetch(input logic [63:0] a, input bit delivered);
    exp_addr_q.push_back(a);
    if (delivered) exp_inst_q.push_back(a);
  endtask

  task automatic wait_addr_left(input string tag, input int left);
    int n = 0;
    while (exp_addr_q.size() > left && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_addr_timeout"}, 64'(n < 100), 64'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!inst_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid_timeout"}, 64'(n < 100), 64'd1);
  endtask

  // Returns at negedge+0 right after the last expected instruction; grants are switched off before the model acts.
  task automatic drain(input string tag);
    int n = 0;
    while ((exp_addr_q.size() != 0 || exp_inst_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    gnt_en = 1'b0;
    check({tag, "_drain_timeout"}, 64'(n < 100), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values and sequential stream 0,4,8
    cyc(2);
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_valid", 64'(inst_valid), 64'd0);
    check("rst_trap", 64'(trap), 64'd0);
    check("rst_inst", 64'(inst), 64'd0);
    check("rst_inst_pc", inst_pc, 64'd0);
    check("rst_addr", imem_addr, 64'h0);
    reset = 1'b0; gnt_en = 1'b1; inst_ready = 1'b1;
    push_fetch(64'h0, 1); push_fetch(64'h4, 1); push_fetch(64'h8, 1);
    cyc(2);
    check("lat_early", 64'(inst_valid), 64'd0);
    cyc(1);
    check("lat_first", 64'(inst_valid), 64'd1);
    drain("seq");

    // Grant withheld: request and address must hold
    do_reset();
    cyc(1);
    for (int i = 0; i < 5; i++) begin
      check("stall_req", 64'(imem_req), 64'd1);
      check("stall_addr", imem_addr, 64'h0);
      cyc(1);
    end
    inst_ready = 1'b1; gnt_en = 1'b1;
    push_fetch(64'h0, 1);
    drain("stall");

    // Redirect while waiting on 0x8: its response must never reach decode
    do_reset();
    gnt_en = 1'b1; inst_ready = 1'b1; rv_delay = 3;
    push_fetch(64'h0, 1); push_fetch(64'h4, 1); push_fetch(64'h8, 0); push_fetch(64'h200, 1);
    wait_addr_left("redir_wait", 1);
    redirect = 1'b1; redirect_pc = 64'h200;
    cyc(1);
    redirect = 1'b0;
    drain("redir_wait");
    rv_delay = 0;

    // Back-pressure in OUT, then ready plus redirect in the same cycle
    do_reset();
    gnt_en = 1'b1;
    push_fetch(64'h0, 1); push_fetch(64'h40, 1);
    wait_valid("hold");
    for (int i = 0; i < 4; i++) begin
      check("hold_valid", 64'(inst_valid), 64'd1);
      check("hold_pc", inst_pc, 64'h0);
      check("hold_inst", 64'(inst), 64'(mem_word(64'h0)));
      cyc(1);
    end
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 64'h40;
    cyc(1);
    redirect = 1'b0;
    drain("hold");

    // Redirect in OUT without ready: instruction dropped
    do_reset();
    gnt_en = 1'b1;
    push_fetch(64'h0, 0); push_fetch(64'h80, 1);
    wait_valid("drop");
    redirect = 1'b1; redirect_pc = 64'h80;
    cyc(1);
    redirect = 1'b0;
    check("drop_valid", 64'(inst_valid), 64'd0);
    inst_ready = 1'b1;
    drain("drop");

    // PC wrap at the top of the address space
    do_reset();
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    gnt_en = 1'b1; inst_ready = 1'b1;
    push_fetch(64'hFFFF_FFFF_FFFF_FFFC, 1); push_fetch(64'h0, 1);
    cyc(1);
    redirect = 1'b0;
    drain("wrap");

    // Misaligned redirect target
    do_reset();
    cyc(1);
    redirect = 1'b1; redirect_pc = 64'h202;
    cyc(1);
    redirect = 1'b0;
`ifdef FETCH_TRAP_EN
    check("trap_pulse", 64'(trap), 64'd1);
    check("trap_addr", imem_addr, 64'h100);
    cyc(1);
    check("trap_clear", 64'(trap), 64'd0);
    push_fetch(64'h100, 1);
`else
    check("trap_quiet", 64'(trap), 64'd0);
    check("trap_addr", imem_addr, 64'h202);
    cyc(1);
    check("trap_quiet2", 64'(trap), 64'd0);
    push_fetch(64'h202, 1);
`endif
    gnt_en = 1'b1; inst_ready = 1'b1;
    drain("trap");

    cyc(2);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
